ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Parametrised iterative RV32M multiply/divide unit beside the execute stage.
- Handles the eight M-extension ops (opcode 0110011, func7 0000001), which the single-cycle ALU does not implement.
- Accepts one operation, holds the pipeline through ctrl via hold_flag_o while it iterates, then returns a one-cycle result beat with the write-back address.

Parameters:
- XLEN, 32: operand/result width.
- STEP_BITS, 1: bits processed per iteration cycle; must divide XLEN (1, 2, 4 legal).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  request valid; sampled only in IDLE.
- func3_i  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1_i  in  XLEN  rs1 value.
- op2_i  in  XLEN  rs2 value.
- rd_addr_i  in  5  destination register.
- rd_wen_i  in  1  write-enable passthrough.
- flush_i  in  1  kill in-flight op (branch/jump from ctrl).
- hold_flag_o  out  1  pipeline hold request to ctrl.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle result strobe.
- rd_data_o  out  XLEN  result, valid when done_o.
- rd_addr_o  out  5  captured rd; valid when done_o, else 0.
- rd_wen_o  out  1  captured rd_wen_i AND done_o.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0. Internal regs 0.
- States: IDLE, CALC, FIN.
- IDLE + start_i:
  - Capture func3, operands, rd_addr, rd_wen.
  - Compute absolute values and result sign. Signedness: MUL/MULH/DIV/REM both operands signed; MULHSU op1 signed, op2 unsigned; MULHU/DIVU/REMU unsigned.
  - Load iteration counter = XLEN/STEP_BITS.
  - Go to CALC, except in the divide special cases below, which go directly to FIN.
- Divide special cases (go directly to FIN, result preset):
  - op2=0: DIV/DIVU -> all ones; REM/REMU -> op1.
  - Signed overflow (DIV/REM, op1 = 1<<(XLEN-1), op2 = all ones): DIV -> op1; REM -> 0.
- CALC:
  - Multiply: shift-add of STEP_BITS multiplier bits per cycle into a 2*XLEN accumulator.
  - Divide: restoring, STEP_BITS quotient bits per cycle.
  - Counter decrements each cycle; at count==1 go to FIN.
- FIN:
  - Apply sign correction. Quotient negated if operand signs differ. Remainder takes the dividend's sign.
  - Select low XLEN bits (MUL), high XLEN bits (MULH*), quotient, or remainder.
  - Drive done_o=1 with rd_data_o/rd_addr_o/rd_wen_o for exactly this cycle, then return to IDLE.
- Latency (start accepted -> done_o):
  - Normal: XLEN/STEP_BITS + 1 cycles (33 at defaults).
  - Special cases: 1 cycle.
- hold_flag_o = (IDLE & start_i & ~flush_i) | CALC. It is low in FIN so the pipeline advances on the result cycle.
- start_i while busy: ignored, no queuing.
- start_i in the done cycle: ignored; the new op is accepted on the next cycle.
- flush_i:
  - In CALC or FIN: return to IDLE next cycle; done_o suppressed. If it coincides with FIN, done_o is forced 0 that cycle.
  - In IDLE with start_i: request dropped.
- Reset mid-operation: immediate IDLE; no done_o.
- All arithmetic is modulo 2^XLEN. MULH results come from the full 2*XLEN signed/unsigned product.

Test Plan:
- MUL: op1=7, op2=-3 (0xFFFFFFFD), rd=5 -> hold high 32 cycles; done_o on cycle 33 with rd_data=0xFFFFFFEB, rd_addr=5, rd_wen=1.
- MULH/MULHSU/MULHU with op1=op2=0x80000000 -> 0x40000000 / 0xC0000000 / 0x40000000.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFFF/16 -> 0x0FFFFFFF. REMU -> 0xF.
- Special cases, each with done_o 1 cycle after start and hold low that cycle:
  - DIV x/0 with op1=0x1234 -> 0xFFFFFFFF.
  - REM x/0 -> 0x1234.
  - DIV 0x80000000/-1 -> 0x80000000.
  - REM 0x80000000/-1 -> 0.
- flush_i pulsed at CALC cycle 10 -> busy drops next cycle, no done_o. A following start 1 cycle later completes correctly. Repeat with flush coinciding with FIN -> no done_o.
- rst_n low at CALC cycle 5 -> all outputs 0 immediately. Repeat all ops at STEP_BITS=2 and 4 -> identical results, latency 17 / 9.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// STEP_BITS bits per cycle, with divide special cases short-circuited to FIN.
module ex_muldiv #(
    parameter int XLEN      = 32,
    parameter int STEP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_wen_i,
    input  logic            flush_i,
    output logic            hold_flag_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_wen_o
);

    localparam int ITERS = XLEN / STEP_BITS;
    localparam int CW    = $clog2(ITERS + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t              state_reg;
    logic [2:0]          func3_reg;
    logic [XLEN-1:0]     divisor_reg;
    logic [2*XLEN-1:0]   acc_reg;
    logic                neg_reg;
    logic [4:0]          rd_addr_reg;
    logic                rd_wen_reg;
    logic [CW-1:0]       count_reg;

    // Operand decode on the request inputs
    logic                is_div, is_rem, op1_signed, op2_signed, s1, s2;
    logic [XLEN-1:0]     abs1, abs2, preset;
    logic                div_zero, div_ovf, special, neg_in;

    always_comb begin
        is_div     = func3_i[2];
        is_rem     = func3_i[1];
        op1_signed = (func3_i == 3'b000) || (func3_i == 3'b001) || (func3_i == 3'b010) ||
                     (func3_i == 3'b100) || (func3_i == 3'b110);
        op2_signed = (func3_i == 3'b000) || (func3_i == 3'b001) ||
                     (func3_i == 3'b100) || (func3_i == 3'b110);
        s1         = op1_signed & op1_i[XLEN-1];
        s2         = op2_signed & op2_i[XLEN-1];
        abs1       = s1 ? -op1_i : op1_i;
        abs2       = s2 ? -op2_i : op2_i;
        div_zero   = is_div && (op2_i == '0);
        div_ovf    = is_div && !func3_i[0] &&
                     (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
        special    = div_zero || div_ovf;
        if (div_zero)
            preset = is_rem ? op1_i : '1;
        else
            preset = is_rem ? '0 : op1_i;
        neg_in     = (is_div && is_rem) ? s1 : (s1 ^ s2);
    end

    // One multiply step: add multiplicand * low digit into the upper half, shift right
    logic [XLEN+STEP_BITS-1:0] partial, upper;
    logic [2*XLEN-1:0]         mul_next;

    always_comb begin
        partial  = {{STEP_BITS{1'b0}}, divisor_reg} *
                   {{XLEN{1'b0}}, acc_reg[STEP_BITS-1:0]};
        upper    = {{STEP_BITS{1'b0}}, acc_reg[2*XLEN-1:XLEN]} + partial;
        mul_next = {upper, acc_reg[XLEN-1:STEP_BITS]};
    end

    // Restoring divide: upper half is partial remainder, lower half shifts dividend out / quotient in
    logic [XLEN-1:0]   rem_w, dq_w;
    logic [XLEN:0]     trial_w;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        rem_w   = acc_reg[2*XLEN-1:XLEN];
        dq_w    = acc_reg[XLEN-1:0];
        trial_w = '0;
        for (int i = 0; i < STEP_BITS; i++) begin
            trial_w = {rem_w, dq_w[XLEN-1]};
            if (trial_w >= {1'b0, divisor_reg}) begin
                rem_w = XLEN'(trial_w - {1'b0, divisor_reg});
                dq_w  = {dq_w[XLEN-2:0], 1'b1};
            end else begin
                rem_w = trial_w[XLEN-1:0];
                dq_w  = {dq_w[XLEN-2:0], 1'b0};
            end
        end
        div_next = {rem_w, dq_w};
    end

    // Sign correction and result selection in FIN
    logic [2*XLEN-1:0] mul_fix;
    logic [XLEN-1:0]   div_half, div_fix, result;

    always_comb begin
        mul_fix  = neg_reg ? -acc_reg : acc_reg;
        div_half = func3_reg[1] ? acc_reg[2*XLEN-1:XLEN] : acc_reg[XLEN-1:0];
        div_fix  = neg_reg ? -div_half : div_half;
        if (func3_reg[2])
            result = div_fix;
        else if (func3_reg[1:0] == 2'b00)
            result = mul_fix[XLEN-1:0];
        else
            result = mul_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            func3_reg   <= '0;
            divisor_reg <= '0;
            acc_reg     <= '0;
            neg_reg     <= 1'b0;
            rd_addr_reg <= '0;
            rd_wen_reg  <= 1'b0;
            count_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i && !flush_i) begin
                        func3_reg   <= func3_i;
                        rd_addr_reg <= rd_addr_i;
                        rd_wen_reg  <= rd_wen_i;
                        divisor_reg <= abs2;
                        count_reg   <= CW'(ITERS);
                        if (special) begin
                            // Preset lands in the half FIN selects for this op
                            acc_reg   <= is_rem ? {preset, {XLEN{1'b0}}} : {{XLEN{1'b0}}, preset};
                            neg_reg   <= 1'b0;
                            state_reg <= FIN;
                        end else begin
                            acc_reg   <= {{XLEN{1'b0}}, abs1};
                            neg_reg   <= neg_in;
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state_reg <= IDLE;
                    end else begin
                        acc_reg   <= func3_reg[2] ? div_next : mul_next;
                        count_reg <= count_reg - 1'b1;
                        if (count_reg == CW'(1))
                            state_reg <= FIN;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign done_o      = (state_reg == FIN) && !flush_i;
    assign busy_o      = (state_reg != IDLE);
    assign hold_flag_o = rst_n && (((state_reg == IDLE) && start_i && !flush_i) ||
                                   (state_reg == CALC));
    assign rd_data_o   = done_o ? result : '0;
    assign rd_addr_o   = done_o ? rd_addr_reg : 5'd0;
    assign rd_wen_o    = done_o && rd_wen_reg;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: three instances (STEP_BITS 1/2/4) run a vector
// table in lockstep, plus flush, idle-flush and mid-operation reset sequences.
module tb_ex_muldiv;

    localparam int ND = 3;
    localparam int NV = 23;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  func3 = '0;
    logic [31:0] op1 = '0, op2 = '0;
    logic [4:0]  rd_addr = '0;
    logic        rd_wen = 1'b0;
    logic        flush = 1'b0;

    logic        hold [ND];
    logic        busy [ND];
    logic        done [ND];
    logic [31:0] rdata [ND];
    logic [4:0]  raddr [ND];
    logic        rwen [ND];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        ex_muldiv #(.XLEN(32), .STEP_BITS(1 << gi)) u_dut (
            .clk(clk), .rst_n(rst_n), .start_i(start), .func3_i(func3),
            .op1_i(op1), .op2_i(op2), .rd_addr_i(rd_addr), .rd_wen_i(rd_wen),
            .flush_i(flush), .hold_flag_o(hold[gi]), .busy_o(busy[gi]),
            .done_o(done[gi]), .rd_data_o(rdata[gi]), .rd_addr_o(raddr[gi]),
            .rd_wen_o(rwen[gi])
        );
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] exp;
        logic        sp;
    } vec_t;

    vec_t vecs [NV];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int d, input int idx,
                       input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s dut%0d vec%0d: got %h want %h", name, d, idx, got, want);
        end
    endtask

    task automatic check_outputs_zero(input string name, input int idx);
        for (int k = 0; k < ND; k++)
            chk(name, k, idx, {hold[k], busy[k], done[k], rwen[k], raddr[k], rdata[k][22:0]} |
                              {9'd0, rdata[k][31:23], 14'd0}, 32'd0);
    endtask

    // Launch one op in the current cycle and watch every instance for 40 cycles
    task automatic apply(input vec_t v, input int idx);
        int done_cnt [ND], done_cyc [ND], hold_cnt [ND], leak [ND];
        logic [31:0] got_data [ND];
        logic [4:0]  got_addr [ND];
        logic        got_wen [ND], got_hold_done [ND];
        func3 = v.f3; op1 = v.a; op2 = v.b; rd_addr = v.rd; rd_wen = v.wen; start = 1'b1;
        #1;
        for (int k = 0; k < ND; k++) begin
            chk("hold_at_start", k, idx, {31'd0, hold[k]}, 32'd1);
            done_cnt[k] = 0; done_cyc[k] = -1; hold_cnt[k] = 0; leak[k] = 0;
            got_data[k] = '0; got_addr[k] = '0; got_wen[k] = 1'b0; got_hold_done[k] = 1'b0;
        end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            for (int k = 0; k < ND; k++) begin
                if (hold[k]) hold_cnt[k]++;
                if (done[k]) begin
                    done_cnt[k]++;
                    if (done_cyc[k] < 0) begin
                        done_cyc[k] = cyc; got_data[k] = rdata[k];
                        got_addr[k] = raddr[k]; got_wen[k] = rwen[k]; got_hold_done[k] = hold[k];
                    end
                end else if (rdata[k] != 0 || raddr[k] != 0 || rwen[k]) begin
                    leak[k]++;
                end
            end
        end
        for (int k = 0; k < ND; k++) begin
            chk("done_count", k, idx, done_cnt[k], 1);
            chk("latency", k, idx, done_cyc[k], v.sp ? 1 : (32 >> k) + 1);
            chk("hold_cycles", k, idx, hold_cnt[k], v.sp ? 0 : (32 >> k));
            chk("hold_at_done", k, idx, {31'd0, got_hold_done[k]}, 32'd0);
            chk("rd_data", k, idx, got_data[k], v.exp);
            chk("rd_addr", k, idx, {27'd0, got_addr[k]}, {27'd0, v.rd});
            chk("rd_wen", k, idx, {31'd0, got_wen[k]}, {31'd0, v.wen});
            chk("idle_outputs", k, idx, leak[k], 0);
        end
    endtask

    initial begin
        int cnt0;
        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  1'b1, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  1'b1, 32'h4000_0000, 1'b0};
        vecs[2]  = '{3'b010, 32'h8000_0000, 32'h8000_0000, 5'd7,  1'b1, 32'hC000_0000, 1'b0};
        vecs[3]  = '{3'b011, 32'h8000_0000, 32'h8000_0000, 5'd8,  1'b1, 32'h4000_0000, 1'b0};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  1'b1, 32'hFFFF_FFFD, 1'b0};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 1'b1, 32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0010, 5'd11, 1'b1, 32'h0FFF_FFFF, 1'b0};
        vecs[7]  = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0010, 5'd12, 1'b1, 32'h0000_000F, 1'b0};
        vecs[8]  = '{3'b100, 32'h0000_1234, 32'h0000_0000, 5'd13, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{3'b110, 32'h0000_1234, 32'h0000_0000, 5'd14, 1'b1, 32'h0000_1234, 1'b1};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1, 32'h8000_0000, 1'b1};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b1, 32'h0000_0000, 1'b1};
        vecs[12] = '{3'b000, 32'h1234_5678, 32'h0000_0009, 5'd17, 1'b0, 32'hA3D7_0A38, 1'b0};
        vecs[13] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 1'b1, 32'hFFFF_FFFE, 1'b0};
        vecs[14] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 1'b1, 32'h0000_0000, 1'b0};
        vecs[15] = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 5'd20, 1'b1, 32'hFFFF_FFFF, 1'b0};
        vecs[16] = '{3'b100, 32'h0000_0064, 32'hFFFF_FFF9, 5'd21, 1'b1, 32'hFFFF_FFF2, 1'b0};
        vecs[17] = '{3'b110, 32'h0000_0064, 32'hFFFF_FFF9, 5'd22, 1'b1, 32'h0000_0002, 1'b0};
        vecs[18] = '{3'b101, 32'h0000_0005, 32'h0000_0000, 5'd23, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[19] = '{3'b111, 32'h0000_0005, 32'h0000_0000, 5'd24, 1'b1, 32'h0000_0005, 1'b1};
        vecs[20] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd25, 1'b1, 32'h0000_0000, 1'b0};
        vecs[21] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd26, 1'b1, 32'h8000_0000, 1'b0};
        vecs[22] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd27, 1'b1, 32'hFFFF_FFFF, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset_outputs", -1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i], i);
            $display("vec %0d func3=%b op1=%h op2=%h exp=%h", i, vecs[i].f3, vecs[i].a,
                     vecs[i].b, vecs[i].exp);
        end

        // Flush during CALC cycle 10, then a new op one cycle later
        @(negedge clk);
        func3 = 3'b000; op1 = 32'd7; op2 = 32'hFFFF_FFFD; rd_addr = 5'd5; rd_wen = 1'b1; start = 1'b1;
        cnt0 = 0;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (cyc == 10);
            #1;
            if (done[0]) cnt0++;
        end
        chk("flush_calc_busy", 0, 100, {31'd0, busy[0]}, 32'd0);
        chk("flush_calc_busy", 1, 100, {31'd0, busy[1]}, 32'd0);
        chk("flush_calc_done", 0, 100, cnt0, 0);
        $display("seq flush in CALC cycle 10");
        apply(vecs[7], 101);
        $display("seq op after flush");

        // Flush coinciding with FIN
        @(negedge clk);
        func3 = 3'b110; op1 = 32'hFFFF_FFF9; op2 = 32'd2; rd_addr = 5'd9; start = 1'b1;
        cnt0 = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (cyc == 33);
            #1;
            if (done[0]) cnt0++;
            if (cyc == 33) begin
                chk("flush_fin_data", 0, 102, rdata[0], 32'd0);
                chk("flush_fin_wen", 0, 102, {31'd0, rwen[0]}, 32'd0);
            end
            if (cyc == 34) chk("flush_fin_busy", 0, 102, {31'd0, busy[0]}, 32'd0);
        end
        chk("flush_fin_done", 0, 102, cnt0, 0);
        $display("seq flush coinciding with FIN");

        // Flush together with start in IDLE drops the request
        func3 = 3'b000; op1 = 32'd3; op2 = 32'd4; start = 1'b1; flush = 1'b1;
        #1;
        for (int k = 0; k < ND; k++) chk("idle_flush_hold", k, 103, {31'd0, hold[k]}, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) chk("idle_flush_busy", k, 103, {31'd0, busy[k]}, 32'd0);
        $display("seq flush with start in IDLE");

        // Reset at CALC cycle 5
        @(negedge clk);
        func3 = 3'b001; op1 = 32'h8000_0000; op2 = 32'h8000_0000; start = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midop_reset", 104);
        @(negedge clk);
        rst_n = 1'b1;
        cnt0 = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            #1;
            for (int k = 0; k < ND; k++) if (done[k] || busy[k]) cnt0++;
        end
        chk("midop_reset_quiet", 0, 104, cnt0, 0);
        $display("seq reset at CALC cycle 5");
        apply(vecs[0], 105);
        $display("seq op after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
